// File: rtl/envelope_follower.sv
// Peak envelope follower: rectifies each frame's sample and moves env toward it
// with attack/release coefficients, a peak-hold window and a serial multiplier.
module envelope_follower #(
    parameter int BITSIZE  = 16,
    parameter int HOLDBITS = 12
) (
    input  logic                       bclk,
    input  logic                       rst_n,
    input  logic                       lrclk,
    input  logic signed [BITSIZE-1:0]  in,
    input  logic        [BITSIZE-1:0]  attack,
    input  logic        [BITSIZE-1:0]  releas,
    input  logic        [HOLDBITS-1:0] hold,
    output logic        [BITSIZE-1:0]  env,
    output logic                       valid,
    output logic                       overrun
);
    localparam int W  = BITSIZE;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]  ENV_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_FS   = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, RECT, SELECT, MUL, SCALE, UPDATE} state_t;
    state_t state, state_nxt;

    logic                lrclk_d;
    logic [W-1:0]        s_in, s_att, s_rel;
    logic [HOLDBITS-1:0] s_hold, holdcnt;
    logic [W-1:0]        mag, diff, coef, step;
    logic                dir_up;
    logic [2*W-1:0]      prod;
    logic [CW-1:0]       cnt;

    logic                lr_rise;
    logic [W-1:0]        sel_diff, sel_coef, neg_in;
    logic                sel_up, sel_reload, sel_hold;
    logic [W:0]          psum, upsum;

    assign lr_rise = lrclk & ~lrclk_d;
    assign neg_in  = -s_in;
    assign psum    = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? diff : '0)};
    assign upsum   = {1'b0, env} + {1'b0, step};

    // Peak beats hold, hold beats release.
    always_comb begin
        sel_up     = 1'b0;
        sel_reload = 1'b0;
        sel_hold   = 1'b0;
        sel_diff   = '0;
        sel_coef   = '0;
        if (mag > env) begin
            sel_up     = 1'b1;
            sel_reload = 1'b1;
            sel_diff   = mag - env;
            sel_coef   = s_att;
        end else if (holdcnt != '0) begin
            sel_hold   = 1'b1;
        end else begin
            sel_diff   = env - mag;
            sel_coef   = s_rel;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lr_rise) state_nxt = RECT;
            RECT:    state_nxt = SELECT;
            SELECT:  state_nxt = MUL;
            MUL:     if (cnt == CNT_LAST) state_nxt = SCALE;
            SCALE:   state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrclk_d <= 1'b0;
            s_in    <= '0;
            s_att   <= '0;
            s_rel   <= '0;
            s_hold  <= '0;
            holdcnt <= '0;
            mag     <= '0;
            diff    <= '0;
            coef    <= '0;
            step    <= '0;
            dir_up  <= 1'b0;
            prod    <= '0;
            cnt     <= '0;
            env     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            lrclk_d <= lrclk;
            valid   <= 1'b0;
            if (lr_rise && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (lr_rise) begin
                        s_in   <= in;
                        s_att  <= attack;
                        s_rel  <= releas;
                        s_hold <= hold;
                    end
                end
                RECT: begin
                    if (s_in == NEG_FS)  mag <= ENV_MAX;
                    else if (s_in[W-1]) mag <= neg_in;
                    else                mag <= s_in;
                end
                SELECT: begin
                    dir_up <= sel_up;
                    diff   <= sel_diff;
                    coef   <= sel_coef;
                    prod   <= {{W{1'b0}}, sel_coef};
                    cnt    <= '0;
                    if (sel_reload)    holdcnt <= s_hold;
                    else if (sel_hold) holdcnt <= holdcnt - HOLDBITS'(1);
                end
                MUL: begin
                    // Multiplier sits in the low half and shifts out as the sum shifts in.
                    prod <= {psum, prod[W-1:1]};
                    cnt  <= cnt + CW'(1);
                end
                SCALE: begin
                    if (prod[2*W-1:W] == '0 && diff != '0 && coef != '0)
                        step <= W'(1);
                    else
                        step <= prod[2*W-1:W];
                end
                UPDATE: begin
                    if (dir_up)
                        env <= (upsum > {1'b0, ENV_MAX}) ? ENV_MAX : upsum[W-1:0];
                    else
                        env <= (step > env) ? '0 : env - step;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/envelope_follower.md
# envelope_follower

Per-sample peak envelope detector that sits directly upstream of the dynamics stage. It rectifies each incoming codec sample, tracks its magnitude with independent attack and release coefficients plus a peak-hold window, and outputs an unsigned envelope word once per frame. The dynamics stage uses that word as its level input instead of the raw sample. Multiplication is serial shift-add, one result per frame.

## Interface

Parameters:
- BITSIZE, 16, sample and coefficient width.
- HOLDBITS, 12, width of the hold counter and the `hold` port.

Ports:
- bclk  in  1  codec bit clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- lrclk  in  1  frame clock; `in` is valid at its rising edge.
- in  in  BITSIZE signed  audio sample.
- attack  in  BITSIZE unsigned  Q0.BITSIZE fraction of the rising difference applied per sample; 0 freezes upward motion.
- releas  in  BITSIZE unsigned  Q0.BITSIZE fraction of the falling difference applied per sample.
- hold  in  HOLDBITS unsigned  number of samples the envelope is frozen after a new peak.
- env  out  BITSIZE unsigned  envelope, range 0..2^(BITSIZE-1)-1.
- valid  out  1  one-bclk pulse when `env` updates.
- overrun  out  1  sticky flag, set when an lrclk edge is dropped.

## Operation

- Reset values:
  - env=0, valid=0, overrun=0.
  - Internal: hold counter=0, lrclk_d=0, state=IDLE.
- Edge detect: `lrclk & ~lrclk_d`, with `lrclk_d` a registered copy of `lrclk`.
- IDLE:
  - On an edge, latch `in`, `attack`, `releas` and `hold`, then go to RECT.
  - Without an edge, `valid` is 0.
- RECT:
  - mag = |in|.
  - -2^(BITSIZE-1) saturates to 2^(BITSIZE-1)-1.
  - Go to SELECT.
- SELECT, first matching case wins:
  - mag > env: dir=up, diff=mag-env, coef=attack, reload the hold counter with the latched `hold`.
  - hold counter ≠ 0: decrement it, diff=0, coef=0.
  - Otherwise: dir=down, diff=env-mag, coef=releas.
  - Then go to MUL.
- MUL:
  - BITSIZE cycles of serial shift-add, computing a 2·BITSIZE-bit product diff·coef.
  - step = product >> BITSIZE.
  - If step=0 while diff≠0 and coef≠0, force step=1 so the envelope converges.
- UPDATE:
  - env ← env+step (up) or env−step (down).
  - Clamp to 0..2^(BITSIZE-1)-1.
  - Set valid=1 and go to IDLE.
- lrclk edge while not in IDLE: the sample is dropped and overrun is set to 1. Overrun is cleared only by reset.
- Simultaneous edge and UPDATE completion: the edge is dropped and counts as an overrun. The frame must therefore be at least BITSIZE+5 bclk long; a codec frame of 32 or 64 bclk satisfies this.
- Reset asserted mid-frame: everything returns to reset values immediately. No valid pulse is produced for the aborted sample.

## Timing

- Capture edge = the bclk edge at which IDLE sees the lrclk edge.
- env and valid change together exactly BITSIZE+4 bclk edges after the capture edge: 20 for BITSIZE=16.
- valid is high for exactly one bclk, then 0 until the next update.
- Latency is the same for attack, release and hold paths. The hold path runs MUL with coef=0 and leaves env unchanged, but still pulses valid.
- env holds its value between pulses.
- attack, releas and hold may change at any time. They take effect only at the next capture edge.
- overrun rises on the bclk edge following the dropped lrclk edge.

## Test plan

- Reset, then run 5 frames with in=0: env=0, overrun=0, and exactly one valid pulse per frame, each 20 bclk after its capture edge.
- attack=0xFFFF, hold=0, in=0x7FFF: env=32766 after frame 1 and 32767 after frame 2 (minimum-step rule). Repeat with in=-32768: identical results, confirming negative full scale saturates.
- Reach env=32767, then hold=3, releas=0x8000, in=0:
  - frames 1-3: env=32767, with valid still pulsing each frame.
  - frame 4: env=16384.
  - frame 5: env=8192.
- Two lrclk rising edges 10 bclk apart: only the first produces a valid pulse, and overrun=1 and stays 1 until rst_n is pulsed low.
- Assert rst_n low during MUL with env=1000, then release it: env=0, valid=0, no valid pulse. The next frame behaves exactly as the first frame after power-up.
- attack=0, releas=0, alternating inputs ±20000: env stays at 0 with valid pulsing. attack=0 blocks any rise, and release has nothing to act on.
